// File: rtl/misc_timer_unit.sv
// misc_timer_unit: prescaled free-running mtime, per-hart mtimecmp with timer irqs, display byte FIFO.
// Latency: write response and read data one cycle after the strobe; timer_irq one cycle after compare inputs.
// Backpressure: FIFO drains via disp_valid/disp_ready; a push into a full FIFO is dropped and sets overflow.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_wen/waddr/wdata/wmask        register write strobe, byte offset, data, byte enables
//   mem_bresp                        write response (OKAY=0, SLVERR=2), held until the next write
//   mem_ren/raddr                    register read strobe and byte offset
//   mem_rdata/mem_rresp              read data and response, held until the next read
//   timer_irq                        per-hart level timer interrupt (mtime >= mtimecmp[i])
//   disp_valid/disp_data/disp_ready  display FIFO head stream
//   misc_mtime/misc_display          cosim copies of mtime and the pushed-byte history
module misc_timer_unit #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned NUM_HARTS    = 4,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [15:0] PRESCALE_RST = 16'd0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_wen,
   input  logic [ADDR_WIDTH-1:0]   mem_waddr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_wmask,
   output logic [1:0]              mem_bresp,
   input  logic                    mem_ren,
   input  logic [ADDR_WIDTH-1:0]   mem_raddr,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [1:0]              mem_rresp,
   output logic [NUM_HARTS-1:0]    timer_irq,
   output logic                    disp_valid,
   output logic [7:0]              disp_data,
   input  logic                    disp_ready,
   output logic [DATA_WIDTH-1:0]   misc_mtime,
   output logic [DATA_WIDTH-1:0]   misc_display
);
   localparam int unsigned NB = DATA_WIDTH / 8;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] OFF_MTIME    = ADDR_WIDTH'(32'h000);
   localparam logic [ADDR_WIDTH-1:0] OFF_PRESCALE = ADDR_WIDTH'(32'h008);
   localparam logic [ADDR_WIDTH-1:0] OFF_DISPLAY  = ADDR_WIDTH'(32'h010);
   localparam logic [ADDR_WIDTH-1:0] OFF_STATUS   = ADDR_WIDTH'(32'h018);
   localparam logic [ADDR_WIDTH-1:0] OFF_CMP_BASE = ADDR_WIDTH'(32'h100);
   localparam logic [ADDR_WIDTH-1:0] OFF_CMP_END  = ADDR_WIDTH'(32'h100 + 8 * NUM_HARTS);

   typedef enum logic [2:0] {
      SEL_ERR,
      SEL_MTIME,
      SEL_PRESCALE,
      SEL_DISPLAY,
      SEL_STATUS,
      SEL_CMP
   } sel_e;

   // Misaligned offsets and holes in the map both decode to SEL_ERR.
   function automatic sel_e decode_addr(input logic [ADDR_WIDTH-1:0] a);
      sel_e s;
      s = SEL_ERR;
      if (a[2:0] == 3'd0) begin
         if (a == OFF_MTIME)         s = SEL_MTIME;
         else if (a == OFF_PRESCALE) s = SEL_PRESCALE;
         else if (a == OFF_DISPLAY)  s = SEL_DISPLAY;
         else if (a == OFF_STATUS)   s = SEL_STATUS;
         else if ((a >= OFF_CMP_BASE) && (a < OFF_CMP_END)) s = SEL_CMP;
      end
      return s;
   endfunction

   // Only meaningful when decode_addr() returned SEL_CMP.
   function automatic logic [HW-1:0] cmp_index(input logic [ADDR_WIDTH-1:0] a);
      return HW'((a - OFF_CMP_BASE) >> 3);
   endfunction

   // Byte-lane merge: masked lanes take new data, the rest keep the old value.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [NB-1:0]         mask
   );
      logic [DATA_WIDTH-1:0] r;
      r = old_v;
      for (int b = 0; b < NB; b++) begin
         if (mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- state
   logic [DATA_WIDTH-1:0] mtime_q,    mtime_d;
   logic [15:0]           pscnt_q,    pscnt_d;
   logic [15:0]           prescale_q, prescale_d;
   logic [DATA_WIDTH-1:0] cmp_q [NUM_HARTS];
   logic [DATA_WIDTH-1:0] cmp_d [NUM_HARTS];
   logic [NUM_HARTS-1:0]  irq_q,      irq_d;
   logic [7:0]            fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wptr_q,     wptr_d;
   logic [PW-1:0]         rptr_q,     rptr_d;
   logic [PW:0]           cnt_q,      cnt_d;
   logic                  ovf_q,      ovf_d;
   logic [DATA_WIDTH-1:0] hist_q,     hist_d;
   logic [1:0]            bresp_q,    bresp_d;
   logic [1:0]            rresp_q,    rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;

   // ---------------------------------------------------------------- decode / control
   sel_e                  wsel;
   sel_e                  rsel;
   logic [HW-1:0]         widx;
   logic [HW-1:0]         ridx;
   logic                  tick;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  pop;
   logic                  push_req;
   logic                  push_ok;
   logic                  ovf_set;
   logic [DATA_WIDTH-1:0] status_word;

   assign wsel = decode_addr(mem_waddr);
   assign rsel = decode_addr(mem_raddr);
   assign widx = cmp_index(mem_waddr);
   assign ridx = cmp_index(mem_raddr);

   assign tick       = (pscnt_q == prescale_q);
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign pop        = !fifo_empty && disp_ready;
   assign push_req   = mem_wen && (wsel == SEL_DISPLAY) && mem_wmask[0];
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok    = push_req && (!fifo_full || pop);
   assign ovf_set    = push_req && fifo_full && !pop;

   always_comb begin
      status_word       = '0;
      status_word[0]    = fifo_empty;
      status_word[1]    = fifo_full;
      status_word[2]    = ovf_q;
      status_word[15:8] = 8'(cnt_q);
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      mtime_d    = mtime_q;
      pscnt_d    = pscnt_q;
      prescale_d = prescale_q;
      cmp_d      = cmp_q;
      irq_d      = '0;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      hist_d     = hist_q;
      bresp_d    = bresp_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;

      // Prescaler and tick; a register write below may override both.
      if (tick) begin
         pscnt_d = '0;
         mtime_d = mtime_q + 1'b1;
      end else begin
         pscnt_d = pscnt_q + 16'd1;
      end

      // Compare uses the registered values, so irq lags writes/ticks by a cycle.
      for (int i = 0; i < NUM_HARTS; i++) begin
         irq_d[i] = (mtime_q >= cmp_q[i]);
      end

      if (mem_wen) begin
         bresp_d = (wsel == SEL_ERR) ? RESP_SLVERR : RESP_OKAY;
         case (wsel)
            SEL_MTIME: begin
               // Write wins over a same-cycle tick: merge onto the old value.
               mtime_d = merge_bytes(mtime_q, mem_wdata, mem_wmask);
            end
            SEL_PRESCALE: begin
               prescale_d = 16'(merge_bytes(DATA_WIDTH'(prescale_q), mem_wdata, mem_wmask));
               pscnt_d    = '0;
            end
            SEL_STATUS: begin
               if (mem_wmask[0] && mem_wdata[2]) ovf_d = 1'b0;
            end
            SEL_CMP: begin
               cmp_d[widx] = merge_bytes(cmp_q[widx], mem_wdata, mem_wmask);
            end
            default: ;
         endcase
      end

      // Display FIFO bookkeeping; set of overflow takes priority over W1C.
      if (push_ok) begin
         wptr_d = wptr_q + 1'b1;
         hist_d = {hist_q[DATA_WIDTH-9:0], mem_wdata[7:0]};
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (ovf_set) ovf_d = 1'b1;

      if (mem_ren) begin
         rresp_d = RESP_OKAY;
         case (rsel)
            SEL_MTIME:    rdata_d = mtime_q;
            SEL_PRESCALE: rdata_d = DATA_WIDTH'(prescale_q);
            SEL_DISPLAY:  rdata_d = hist_q;
            SEL_STATUS:   rdata_d = status_word;
            SEL_CMP:      rdata_d = cmp_q[ridx];
            default: begin
               rdata_d = '1;
               rresp_d = RESP_SLVERR;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= '0;
         pscnt_q    <= '0;
         prescale_q <= PRESCALE_RST;
         for (int i = 0; i < NUM_HARTS; i++) cmp_q[i] <= '1;
         irq_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         hist_q     <= '0;
         bresp_q    <= RESP_OKAY;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         mtime_q    <= mtime_d;
         pscnt_q    <= pscnt_d;
         prescale_q <= prescale_d;
         cmp_q      <= cmp_d;
         irq_q      <= irq_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         hist_q     <= hist_d;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) fifo_mem_q[wptr_q] <= mem_wdata[7:0];
   end

   // ---------------------------------------------------------------- outputs
   assign mem_bresp    = bresp_q;
   assign mem_rresp    = rresp_q;
   assign mem_rdata    = rdata_q;
   assign timer_irq    = irq_q;
   assign disp_valid   = !fifo_empty;
   assign disp_data    = fifo_empty ? 8'h00 : fifo_mem_q[rptr_q];
   assign misc_mtime   = mtime_q;
   assign misc_display = hist_q;

endmodule
